// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between the UART receiver core and the register interface.
// Stores {frame_err, data} per entry; the head is presented show-ahead and popped on read acknowledge.
module uart_rx_fifo #(
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_frame_err_i,
    input  logic              rd_en_i,
    input  logic              flush_i,
    input  logic              clr_overrun_i,
    input  logic [CNT_W-1:0]  watermark_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_frame_err_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overrun_o,
    output logic              irq_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W:0]    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overrun;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               drop;
    logic [DATA_W:0]    head;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign push = wr_valid_i && (!full || rd_en_i);
    assign pop  = rd_en_i && !empty;
    assign drop = wr_valid_i && full && !rd_en_i;

    // Storage is not reset; only the pointers and count define valid content.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && push) begin
            mem[wr_ptr] <= {wr_frame_err_i, wr_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Set beats clear; a byte discarded by a flush is not an overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop && !flush_i) begin
            overrun <= 1'b1;
        end else if (clr_overrun_i) begin
            overrun <= 1'b0;
        end
    end

    assign head           = mem[rd_ptr];
    assign rd_data_o      = empty ? '0 : head[DATA_W-1:0];
    assign rd_frame_err_o = empty ? 1'b0 : head[DATA_W];
    assign empty_o        = empty;
    assign full_o         = full;
    assign count_o        = count;
    assign overrun_o      = overrun;
    assign irq_o          = (count > watermark_i);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid_i = 1'b0;
    logic [DATA_W-1:0] wr_data_i = '0;
    logic              wr_frame_err_i = 1'b0;
    logic              rd_en_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              clr_overrun_i = 1'b0;
    logic [CNT_W-1:0]  watermark_i = CNT_W'(DEPTH);
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_frame_err_o;
    logic              empty_o;
    logic              full_o;
    logic [CNT_W-1:0]  count_o;
    logic              overrun_o;
    logic              irq_o;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of {frame_err, data} entries and a sticky overrun bit.
    logic [DATA_W:0] mq[$];
    bit              m_ovr = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid_i     (wr_valid_i),
        .wr_data_i      (wr_data_i),
        .wr_frame_err_i (wr_frame_err_i),
        .rd_en_i        (rd_en_i),
        .flush_i        (flush_i),
        .clr_overrun_i  (clr_overrun_i),
        .watermark_i    (watermark_i),
        .rd_data_o      (rd_data_o),
        .rd_frame_err_o (rd_frame_err_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .count_o        (count_o),
        .overrun_o      (overrun_o),
        .irq_o          (irq_o)
    );

    always #5 clk = ~clk;

    // One clock: model follows the same inputs the DUT samples, outputs are settled 1ns later.
    task automatic tick();
        bit was_full;
        bit was_empty;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_ovr = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (flush_i) begin
                mq.delete();
            end else begin
                if (rd_en_i && !was_empty) void'(mq.pop_front());
                if (wr_valid_i && (!was_full || rd_en_i)) mq.push_back({wr_frame_err_i, wr_data_i});
            end
            if (wr_valid_i && was_full && !rd_en_i && !flush_i) m_ovr = 1'b1;
            else if (clr_overrun_i) m_ovr = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0;
        clr_overrun_i = 1'b0; wr_frame_err_i = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic fe);
        wr_valid_i = 1'b1; wr_data_i = d; wr_frame_err_i = fe;
        tick();
        idle_inputs();
    endtask

    task automatic pop_byte();
        rd_en_i = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_inputs();
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (empty_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %0b expected 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %0b expected 0", full_o); end
        checks++; if (count_o !== 4'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %0b expected 0", overrun_o); end
        checks++; if (rd_data_o !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %0h expected 0", rd_data_o); end
        checks++; if (rd_frame_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_fe: got %0b expected 0", rd_frame_err_o); end
        checks++; if (irq_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq: got %0b expected 0", irq_o); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_after[3];
        exp_after[0] = 8'h42; exp_after[1] = 8'h43; exp_after[2] = 8'h00;
        push_byte(8'h41, 1'b0); push_byte(8'h42, 1'b0); push_byte(8'h43, 1'b0);
        checks++; if (count_o !== 4'd3) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 3", count_o); end
        checks++; if (rd_data_o !== 8'h41) begin failures++; $display("[TB] FAIL basic_head: got %0h expected 41", rd_data_o); end
        checks++; if (empty_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_empty: got %0b expected 0", empty_o); end
        for (int i = 0; i < 3; i++) begin
            pop_byte();
            checks++; if (rd_data_o !== exp_after[i]) begin failures++; $display("[TB] FAIL basic_pop%0d: got %0h expected %0h", i, rd_data_o, exp_after[i]); end
        end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_drained: got %0b expected 1", empty_o); end
        pop_byte();
        checks++; if (count_o !== 4'd0) begin failures++; $display("[TB] FAIL basic_pop_empty: got %0d expected 0", count_o); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) begin
            push_byte(8'(i), 1'b0);
            if (i == 7) begin
                checks++; if (full_o !== 1'b1) begin failures++; $display("[TB] FAIL ovr_full: got %0b expected 1", full_o); end
                checks++; if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL ovr_early: got %0b expected 0", overrun_o); end
            end
        end
        checks++; if (overrun_o !== 1'b1) begin failures++; $display("[TB] FAIL ovr_set: got %0b expected 1", overrun_o); end
        checks++; if (count_o !== 4'd8) begin failures++; $display("[TB] FAIL ovr_count: got %0d expected 8", count_o); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rd_data_o !== 8'(i)) begin failures++; $display("[TB] FAIL ovr_drain%0d: got %0h expected %0h", i, rd_data_o, 8'(i)); end
            pop_byte();
        end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("[TB] FAIL ovr_empty: got %0b expected 1", empty_o); end
        flush_i = 1'b1; tick(); idle_inputs();
        checks++; if (overrun_o !== 1'b1) begin failures++; $display("[TB] FAIL ovr_sticky: got %0b expected 1", overrun_o); end
        clr_overrun_i = 1'b1; tick(); idle_inputs();
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL ovr_clear: got %0b expected 0", overrun_o); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        wr_valid_i = 1'b1; wr_data_i = 8'hAA; rd_en_i = 1'b1;
        tick(); idle_inputs();
        checks++; if (count_o !== 4'd8) begin failures++; $display("[TB] FAIL fpp_count: got %0d expected 8", count_o); end
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL fpp_overrun: got %0b expected 0", overrun_o); end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                checks++; if (rd_data_o !== 8'hAA) begin failures++; $display("[TB] FAIL fpp_aa: got %0h expected aa", rd_data_o); end
            end else begin
                checks++; if (rd_data_o !== mq[0][7:0]) begin failures++; $display("[TB] FAIL fpp_pop%0d: got %0h expected %0h", i, rd_data_o, mq[0][7:0]); end
            end
            pop_byte();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] expected[$];
        logic [7:0] d;
        logic [7:0] e;
        int max_cnt = 0;
        for (int i = 0; i < 2; i++) begin d = 8'($urandom); expected.push_back(d); push_byte(d, 1'b0); end
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom); expected.push_back(d); push_byte(d, 1'b0);
            if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
            e = expected.pop_front();
            checks++; if (rd_data_o !== e) begin failures++; $display("[TB] FAIL wrap_data%0d: got %0h expected %0h", i, rd_data_o, e); end
            pop_byte();
        end
        checks++; if (max_cnt > 3) begin failures++; $display("[TB] FAIL wrap_maxcount: got %0d expected <=3", max_cnt); end
        flush_i = 1'b1; tick(); idle_inputs();
    endtask

    task automatic test_watermark();
        logic exp_irq[3];
        exp_irq[0] = 1'b0; exp_irq[1] = 1'b0; exp_irq[2] = 1'b1;
        watermark_i = 4'd2;
        for (int i = 0; i < 3; i++) begin
            push_byte(8'($urandom), 1'b0);
            checks++; if (irq_o !== exp_irq[i]) begin failures++; $display("[TB] FAIL wm_irq%0d: got %0b expected %0b", i + 1, irq_o, exp_irq[i]); end
        end
        pop_byte();
        checks++; if (irq_o !== 1'b0) begin failures++; $display("[TB] FAIL wm_after_pop: got %0b expected 0", irq_o); end
        watermark_i = CNT_W'(DEPTH);
        flush_i = 1'b1; tick(); idle_inputs();
    endtask

    task automatic test_frame_flush_reset();
        push_byte(8'h55, 1'b1);
        checks++; if (rd_frame_err_o !== 1'b1) begin failures++; $display("[TB] FAIL fe_head: got %0b expected 1", rd_frame_err_o); end
        checks++; if (rd_data_o !== 8'h55) begin failures++; $display("[TB] FAIL fe_data: got %0h expected 55", rd_data_o); end
        push_byte(8'h12, 1'b0); push_byte(8'h34, 1'b0);
        flush_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 8'h99; tick(); idle_inputs();
        checks++; if (count_o !== 4'd0) begin failures++; $display("[TB] FAIL flush_count: got %0d expected 0", count_o); end
        checks++; if (rd_data_o !== 8'h00) begin failures++; $display("[TB] FAIL flush_data: got %0h expected 0", rd_data_o); end
        tick();
        checks++; if (empty_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_discard: got %0b expected 1", empty_o); end
        push_byte(8'h77, 1'b1); push_byte(8'h66, 1'b0);
        watermark_i = 4'd0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (count_o !== 4'd0) begin failures++; $display("[TB] FAIL rst_count: got %0d expected 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_empty: got %0b expected 1", empty_o); end
        checks++; if (rd_data_o !== 8'h00) begin failures++; $display("[TB] FAIL rst_data: got %0h expected 0", rd_data_o); end
        checks++; if (rd_frame_err_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_fe: got %0b expected 0", rd_frame_err_o); end
        checks++; if (irq_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_irq: got %0b expected 0", irq_o); end
        watermark_i = CNT_W'(DEPTH);
    endtask

    task automatic test_random();
        logic [7:0]       exp_data;
        logic             exp_fe;
        logic [CNT_W-1:0] exp_cnt;
        for (int i = 0; i < 400; i++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            wr_valid_i     = ($urandom_range(0, 99) < 55);
            wr_data_i      = 8'($urandom);
            wr_frame_err_i = ($urandom_range(0, 3) == 0);
            rd_en_i        = ($urandom_range(0, 99) < 45);
            flush_i        = ($urandom_range(0, 49) == 0);
            clr_overrun_i  = ($urandom_range(0, 19) == 0);
            watermark_i    = CNT_W'($urandom_range(0, DEPTH + 2));
            tick();
            exp_cnt  = CNT_W'(mq.size());
            exp_data = (mq.size() == 0) ? 8'h00 : mq[0][7:0];
            exp_fe   = (mq.size() == 0) ? 1'b0 : mq[0][8];
            checks++; if (count_o !== exp_cnt) begin failures++; $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", i, count_o, exp_cnt); end
            checks++; if (rd_data_o !== exp_data) begin failures++; $display("[TB] FAIL rnd_data@%0d: got %0h expected %0h", i, rd_data_o, exp_data); end
            checks++; if (rd_frame_err_o !== exp_fe) begin failures++; $display("[TB] FAIL rnd_fe@%0d: got %0b expected %0b", i, rd_frame_err_o, exp_fe); end
            checks++; if (empty_o !== (mq.size() == 0)) begin failures++; $display("[TB] FAIL rnd_empty@%0d: got %0b expected %0b", i, empty_o, mq.size() == 0); end
            checks++; if (full_o !== (mq.size() == DEPTH)) begin failures++; $display("[TB] FAIL rnd_full@%0d: got %0b expected %0b", i, full_o, mq.size() == DEPTH); end
            checks++; if (overrun_o !== m_ovr) begin failures++; $display("[TB] FAIL rnd_overrun@%0d: got %0b expected %0b", i, overrun_o, m_ovr); end
            checks++; if (irq_o !== (mq.size() > int'(watermark_i))) begin failures++; $display("[TB] FAIL rnd_irq@%0d: got %0b expected %0b", i, irq_o, mq.size() > int'(watermark_i)); end
        end
        rst_n = 1'b1; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_push_pop();
        test_wrap();
        test_watermark();
        test_frame_flush_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
